// File: rtl/sa_pkg.sv
// sa_pkg: shared state type, default geometry and width helpers for the systolic stream controller
package sa_pkg;
    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} sa_state_t;
    localparam int SA_ROWS = 8;
    localparam int SA_COLS = 8;
    localparam int SA_INWIDTH = 8;
    localparam int SA_OUTWIDTH = 32;
    localparam int SA_KMAX = 256;
    function automatic int kw(input int kmax);
        return $clog2(kmax + 1);
    endfunction
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sa_stream_ctrl_if.sv
// sa_stream_ctrl_if: operand input stream and result output stream of the controller
interface sa_stream_ctrl_if
    import sa_pkg::*;
#(
    parameter int ROWS = SA_ROWS,
    parameter int COLS = SA_COLS,
    parameter int INWIDTH = SA_INWIDTH,
    parameter int OUTWIDTH = SA_OUTWIDTH
);
    logic in_valid;
    logic in_ready;
    logic [ROWS*INWIDTH-1:0] a_in;
    logic [COLS*INWIDTH-1:0] w_in;
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic [COLS*OUTWIDTH-1:0] out_data;
    logic [idx_w(ROWS)-1:0] out_row;
    modport master (
        output in_valid, a_in, w_in, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last
    );
    modport slave (
        input  in_valid, a_in, w_in, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last
    );
endinterface

// File: rtl/sa_skew_line.sv
// sa_skew_line: enable-gated delay line of DEPTH stages; DEPTH=0 is a plain wire
module sa_skew_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    if (DEPTH == 0) begin : g_pass
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, en};
        assign q = d;
    end else begin : g_line
        logic [WIDTH-1:0] sr [DEPTH];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else if (en) begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[DEPTH-1];
    end
endmodule

// File: rtl/sa_stream_ctrl.sv
// sa_stream_ctrl: skews operand beats into a systolic array, flushes the wavefront, then drains results row by row
module sa_stream_ctrl
    import sa_pkg::*;
#(
    parameter int ROWS = SA_ROWS,
    parameter int COLS = SA_COLS,
    parameter int INWIDTH = SA_INWIDTH,
    parameter int OUTWIDTH = SA_OUTWIDTH,
    parameter int KMAX = SA_KMAX,
    localparam int KW = kw(KMAX),
    localparam int RW = idx_w(ROWS),
    localparam int FW = idx_w(ROWS + COLS)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic [KW-1:0] cfg_k,
    sa_stream_ctrl_if.slave s,
    output logic [ROWS*INWIDTH-1:0] arr_a,
    output logic [COLS*INWIDTH-1:0] arr_w,
    output logic arr_fire,
    output logic arr_clear,
    input  logic [ROWS*COLS*OUTWIDTH-1:0] arr_acc,
    output logic busy,
    output logic done,
    output logic err
);
    localparam int FLUSH_LAST = ROWS + COLS - 2;
    sa_state_t state, state_n;
    logic [KW-1:0] k_q, beat;
    logic [FW-1:0] fcnt;
    logic [RW-1:0] row;
    logic first_q, k_ok, accept, beat_out, to_drain;
    logic [ROWS*COLS*OUTWIDTH-1:0] acc_buf;
    logic [ROWS*INWIDTH-1:0] a_src;
    logic [COLS*INWIDTH-1:0] w_src;
    assign k_ok = cfg_k != '0 && cfg_k <= KW'(KMAX);
    assign to_drain = state == FLUSH && fcnt == FW'(FLUSH_LAST);
    always_comb begin
        state_n = state;
        s.in_ready = state == FEED;
        accept = s.in_valid && s.in_ready;
        arr_fire = accept || state == FLUSH;
        arr_clear = (state == IDLE && start && k_ok) || first_q;
        err = state == IDLE && start && !k_ok;
        busy = state != IDLE;
        s.out_valid = state == DRAIN;
        s.out_last = s.out_valid && row == RW'(ROWS - 1);
        beat_out = s.out_valid && s.out_ready;
        case (state)
            IDLE:    state_n = start && k_ok ? FEED : IDLE;
            FEED:    state_n = accept && beat == k_q - 1'b1 ? FLUSH : FEED;
            FLUSH:   state_n = to_drain ? DRAIN : FLUSH;
            default: state_n = beat_out && s.out_last ? IDLE : DRAIN;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
            beat <= '0;
            fcnt <= '0;
            row <= '0;
            first_q <= 1'b0;
            done <= 1'b0;
            acc_buf <= '0;
        end else begin
            k_q <= state == IDLE && start ? cfg_k : k_q;
            beat <= state == FEED ? beat + KW'(accept) : '0;
            fcnt <= state == FLUSH ? fcnt + 1'b1 : '0;
            row <= state == DRAIN ? row + RW'(beat_out) : '0;
            first_q <= to_drain;
            done <= beat_out && s.out_last;
            acc_buf <= to_drain ? arr_acc : acc_buf;
        end
    end
    assign s.out_data = acc_buf[row*COLS*OUTWIDTH +: COLS*OUTWIDTH];
    assign s.out_row = row;
    // outside FEED the lines see zeros, so FLUSH drains them clean and lane 0 stays quiet
    assign a_src = s.in_ready ? s.a_in : '0;
    assign w_src = s.in_ready ? s.w_in : '0;
    for (genvar i = 0; i < ROWS; i++) begin : g_a
        sa_skew_line #(.WIDTH(INWIDTH), .DEPTH(i)) u_a (
            .clk(clk), .rst(rst), .en(arr_fire),
            .d(a_src[i*INWIDTH +: INWIDTH]), .q(arr_a[i*INWIDTH +: INWIDTH])
        );
    end
    for (genvar j = 0; j < COLS; j++) begin : g_w
        sa_skew_line #(.WIDTH(INWIDTH), .DEPTH(j)) u_w (
            .clk(clk), .rst(rst), .en(arr_fire),
            .d(w_src[j*INWIDTH +: INWIDTH]), .q(arr_w[j*INWIDTH +: INWIDTH])
        );
    end
endmodule

// File: tb/tb_sa_stream_ctrl.sv
// tb_sa_stream_ctrl: random tiles through the controller and a behavioural PE array, checked against a software matmul
module tb_sa_stream_ctrl;
    localparam int R = 8;
    localparam int C = 8;
    localparam int IW = 8;
    localparam int OW = 32;
    localparam int KMAX = 256;
    localparam int KW = $clog2(KMAX + 1);
    logic clk = 0;
    logic rst = 1;
    logic start = 0;
    logic [KW-1:0] cfg_k = '0;
    logic [R*IW-1:0] arr_a;
    logic [C*IW-1:0] arr_w;
    logic arr_fire, arr_clear, busy, done, err;
    logic [R*C*OW-1:0] arr_acc;
    int total = 0;
    int bad = 0;
    logic [IW-1:0] ga [KMAX][R];
    logic [IW-1:0] gw [KMAX][C];
    logic [OW-1:0] mm [R][C];
    logic [OW-1:0] acc [R][C];
    logic [IW-1:0] ah [R][C];
    logic [IW-1:0] wv [R][C];

    sa_stream_ctrl_if #(.ROWS(R), .COLS(C), .INWIDTH(IW), .OUTWIDTH(OW)) bus ();

    sa_stream_ctrl #(.ROWS(R), .COLS(C), .INWIDTH(IW), .OUTWIDTH(OW), .KMAX(KMAX)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .s(bus),
        .arr_a(arr_a), .arr_w(arr_w), .arr_fire(arr_fire), .arr_clear(arr_clear),
        .arr_acc(arr_acc), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // output-stationary PE array: operands hop right/down one PE per fire, each PE accumulates a*w
    function automatic logic [IW-1:0] pa(input int r, input int c);
        return c == 0 ? arr_a[r*IW +: IW] : ah[r][c == 0 ? 0 : c - 1];
    endfunction
    function automatic logic [IW-1:0] pw(input int r, input int c);
        return r == 0 ? arr_w[c*IW +: IW] : wv[r == 0 ? 0 : r - 1][c];
    endfunction
    always @(posedge clk) begin
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                if (rst || arr_clear) acc[r][c] <= '0;
                else if (arr_fire) acc[r][c] <= acc[r][c] + OW'(pa(r, c)) * OW'(pw(r, c));
                if (rst) begin
                    ah[r][c] <= '0;
                    wv[r][c] <= '0;
                end else if (arr_fire) begin
                    ah[r][c] <= pa(r, c);
                    wv[r][c] <= pw(r, c);
                end
            end
    end
    always_comb begin
        arr_acc = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) arr_acc[(r*C+c)*OW +: OW] = acc[r][c];
    end

    task automatic check(input string tag, input logic [C*OW-1:0] obs, input logic [C*OW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [R*IW-1:0] pack_a(input int t);
        logic [R*IW-1:0] v = '0;
        for (int i = 0; i < R; i++) v[i*IW +: IW] = ga[t][i];
        return v;
    endfunction
    function automatic logic [C*IW-1:0] pack_w(input int t);
        logic [C*IW-1:0] v = '0;
        for (int j = 0; j < C; j++) v[j*IW +: IW] = gw[t][j];
        return v;
    endfunction
    // lane i at the nf-th fire carries beat nf-i; on a gap lane 0 shows the raw input
    function automatic logic [R*IW-1:0] exp_a(input int nf, input int k, input bit gap, input logic [R*IW-1:0] cur);
        logic [R*IW-1:0] v = '0;
        for (int i = 0; i < R; i++)
            v[i*IW +: IW] = (gap && i == 0) ? cur[IW-1:0] : (nf - i >= 0 && nf - i < k) ? ga[nf-i][i] : '0;
        return v;
    endfunction
    function automatic logic [C*IW-1:0] exp_w(input int nf, input int k, input bit gap, input logic [C*IW-1:0] cur);
        logic [C*IW-1:0] v = '0;
        for (int j = 0; j < C; j++)
            v[j*IW +: IW] = (gap && j == 0) ? cur[IW-1:0] : (nf - j >= 0 && nf - j < k) ? gw[nf-j][j] : '0;
        return v;
    endfunction
    function automatic logic [C*OW-1:0] mm_row(input int r);
        logic [C*OW-1:0] v = '0;
        for (int c = 0; c < C; c++) v[c*OW +: OW] = mm[r][c];
        return v;
    endfunction

    // vmode: 0 always valid, 1 toggling 1-0-1-0, 2 random; rmode: random out_ready; bs: start held while busy
    task automatic run_tile(input int k, input int vmode, input bit rmode, input int srow, input int slen, input bit bs);
        int nf, na, cyc, fl, row, st, dc;
        bit v, rdy;
        for (int t = 0; t < k; t++) begin
            for (int i = 0; i < R; i++) ga[t][i] = IW'($urandom);
            for (int j = 0; j < C; j++) gw[t][j] = IW'($urandom);
        end
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                mm[r][c] = '0;
                for (int t = 0; t < k; t++) mm[r][c] += OW'(ga[t][r]) * OW'(gw[t][c]);
            end
        @(posedge clk); #1;
        start = 1;
        cfg_k = KW'(k);
        @(negedge clk);
        check("start_clear", arr_clear, 1);
        check("start_err", err, 0);
        @(posedge clk); #1;
        start = 0;
        nf = 0;
        na = 0;
        cyc = 0;
        while (na < k && cyc < 8 * k + 64) begin
            v = vmode == 0 ? 1'b1 : vmode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
            bus.in_valid = v;
            bus.a_in = v ? pack_a(na) : {$urandom, $urandom};
            bus.w_in = v ? pack_w(na) : {$urandom, $urandom};
            @(negedge clk);
            check("feed_ready", bus.in_ready, 1);
            check("feed_busy", busy, 1);
            check("feed_fire", arr_fire, v);
            check("feed_skew_a", arr_a, exp_a(nf, k, !v, bus.a_in));
            check("feed_skew_w", arr_w, exp_w(nf, k, !v, bus.w_in));
            if (v) begin
                na++;
                nf++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        check("feed_accepts", na, k);
        bus.in_valid = 1;
        bus.a_in = {$urandom, $urandom};
        bus.w_in = {$urandom, $urandom};
        start = bs;
        cfg_k = '0;
        fl = 0;
        while (fl < R + C + 8) begin
            @(negedge clk);
            if (bus.out_valid) break;
            check("flush_ready", bus.in_ready, 0);
            check("flush_fire", arr_fire, 1);
            check("flush_err", err, 0);
            check("flush_skew_a", arr_a, exp_a(nf, k, 1'b0, '0));
            check("flush_skew_w", arr_w, exp_w(nf, k, 1'b0, '0));
            nf++;
            fl++;
            @(posedge clk); #1;
        end
        check("flush_len", fl, R + C - 1);
        bus.in_valid = 0;
        cfg_k = KW'(1);
        row = 0;
        st = 0;
        dc = 0;
        while (row < R && dc < 200 + slen) begin
            check("drain_valid", bus.out_valid, 1);
            check("drain_row", bus.out_row, row);
            check("drain_data", bus.out_data, mm_row(row));
            check("drain_last", bus.out_last, row == R - 1);
            check("drain_clear", arr_clear, dc == 0);
            check("drain_fire", arr_fire, 0);
            check("drain_busy", busy, 1);
            rdy = (row == srow && st < slen) ? 1'b0 : rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (row == srow && st < slen) st++;
            bus.out_ready = rdy;
            if (rdy && row == R - 1) start = 0;
            if (rdy) row++;
            dc++;
            @(posedge clk); #1;
            bus.out_ready = 0;
            @(negedge clk);
        end
        start = 0;
        check("drain_beats", row, R);
        check("done_pulse", done, 1);
        check("done_idle", busy, 0);
        check("done_no_valid", bus.out_valid, 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("idle_stays", busy, 0);
    endtask

    initial begin
        bus.in_valid = 0;
        bus.a_in = '0;
        bus.w_in = '0;
        bus.out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ready", bus.in_ready, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_last", bus.out_last, 0);
        check("rst_fire", arr_fire, 0);
        check("rst_clear", arr_clear, 0);
        check("rst_arr_a", arr_a, 0);
        check("rst_arr_w", arr_w, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_row", bus.out_row, 0);
        @(posedge clk); #1;
        rst = 0;

        run_tile(1, 0, 1'b0, -1, 0, 1'b0);
        run_tile(4, 1, 1'b0, -1, 0, 1'b0);
        run_tile(6, 0, 1'b0, 3, 5, 1'b1);

        @(posedge clk); #1;
        start = 1;
        cfg_k = '0;
        @(negedge clk);
        check("err_k0", err, 1);
        check("err_k0_busy", busy, 0);
        check("err_k0_ready", bus.in_ready, 0);
        check("err_k0_clear", arr_clear, 0);
        @(posedge clk); #1;
        cfg_k = KW'(KMAX + 1);
        @(negedge clk);
        check("err_kmax1", err, 1);
        check("err_kmax1_busy", busy, 0);
        check("err_kmax1_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("err_gone", err, 0);
        check("err_still_idle", busy, 0);

        @(posedge clk); #1;
        start = 1;
        cfg_k = KW'(4);
        @(posedge clk); #1;
        start = 0;
        repeat (2) begin
            bus.in_valid = 1;
            bus.a_in = {$urandom, $urandom} | 64'h0101_0101_0101_0101;
            bus.w_in = {$urandom, $urandom} | 64'h0101_0101_0101_0101;
            @(posedge clk); #1;
        end
        rst = 1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_ready", bus.in_ready, 0);
        check("abort_fire", arr_fire, 0);
        check("abort_valid", bus.out_valid, 0);
        check("abort_done", done, 0);
        check("abort_arr_a", arr_a, 0);
        check("abort_arr_w", arr_w, 0);
        bus.in_valid = 0;
        rst = 0;
        run_tile(1, 0, 1'b0, -1, 0, 1'b0);

        run_tile(KMAX, 2, 1'b1, -1, 0, 1'b0);
        repeat (4) run_tile($urandom_range(1, 12), 2, 1'b1, $urandom_range(0, R - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
